// File: rtl/st_pipe_pkg.sv
// Shared definitions for the stage pipeline registers.
// Holds the control-word bit map, the bubble encoding, default field widths
// and the per-edge action decode used by every stage register.
package st_pipe_pkg;

  // Default field widths.
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CTRL_W_DEF = 16;
  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  // Control-word bit positions.
  localparam int unsigned CTRL_REGWRITE = 15;
  localparam int unsigned CTRL_MEMREAD  = 14;
  localparam int unsigned CTRL_MEMWRITE = 13;

  // A bubble carries no live control bits.
  localparam logic [15:0] CTRL_BUBBLE = 16'h0000;

  // What a stage register does on a given rising edge.
  typedef enum logic [1:0] {
    ActLoad  = 2'd0,
    ActHold  = 2'd1,
    ActFlush = 2'd2
  } stageAct_e;

  // Flush beats stall; stall beats load.
  function automatic stageAct_e decodeAct(input logic flush, input logic stall);
    if (flush) begin
      return ActFlush;
    end else if (stall) begin
      return ActHold;
    end else begin
      return ActLoad;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, zeroes the count
//   clr   - synchronous clear, wins over inc
//   inc   - add one this edge unless already at all-ones
//   count - current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] countQ;
  logic [CNT_W-1:0] countD;
  logic             atMax;

  assign atMax = (countQ == {CNT_W{1'b1}});

  always_comb begin
    countD = countQ;
    if (clr) begin
      countD = '0;
    end else if (inc && !atMax) begin
      countD = countQ + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

  assign count = countQ;

endmodule

// File: rtl/st2_idex_reg.sv
// ID/EX pipeline register.
// Captures the stage-2 control word and decoded operands and presents them to
// EX one cycle later. Supports stall (hold), flush (bubble) and a valid bit,
// exports the EX load indication for the hazard unit, and counts bubbles.
// Ports:
//   clk, rst               - clock; asynchronous active-high reset
//   stall, flush           - hold / bubble insertion from the hazard unit
//   cnt_clr                - synchronous clear of bubble_cnt
//   id_*                   - ID-stage valid, control, PC+4, operands, specifiers
//   ex_*                   - registered copies for EX
//   ex_memRead             - registered load indication qualified by valid
//   bubble_cnt             - saturating count of bubbles entering EX
module st2_idex_reg
  import st_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_memRead,
  output logic [CNT_W-1:0]  bubble_cnt
);

  stageAct_e act;

  logic              validQ, validD;
  logic [CTRL_W-1:0] ctrlQ, ctrlD;
  logic [DATA_W-1:0] pc4Q, pc4D;
  logic [DATA_W-1:0] rsDataQ, rsDataD;
  logic [DATA_W-1:0] rtDataQ, rtDataD;
  logic [DATA_W-1:0] immQ, immD;
  logic [REG_W-1:0]  rsQ, rsD;
  logic [REG_W-1:0]  rtQ, rtD;
  logic [REG_W-1:0]  rdQ, rdD;
  logic              bubbleIn;

  assign act = decodeAct(flush, stall);

  always_comb begin
    validD  = validQ;
    ctrlD   = ctrlQ;
    pc4D    = pc4Q;
    rsDataD = rsDataQ;
    rtDataD = rtDataQ;
    immD    = immQ;
    rsD     = rsQ;
    rtD     = rtQ;
    rdD     = rdQ;
    unique case (act)
      ActFlush: begin
        // Data fields still load so the bubble slot is deterministic.
        validD  = 1'b0;
        ctrlD   = '0;
        pc4D    = id_pc4;
        rsDataD = id_rs_data;
        rtDataD = id_rt_data;
        immD    = id_imm;
        rsD     = id_rs;
        rtD     = id_rt;
        rdD     = id_rd;
      end
      ActLoad: begin
        validD  = id_valid;
        // A non-valid slot must never carry live control bits.
        ctrlD   = id_valid ? id_ctrl : '0;
        pc4D    = id_pc4;
        rsDataD = id_rs_data;
        rtDataD = id_rt_data;
        immD    = id_imm;
        rsD     = id_rs;
        rtD     = id_rt;
        rdD     = id_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ  <= 1'b0;
      ctrlQ   <= '0;
      pc4Q    <= '0;
      rsDataQ <= '0;
      rtDataQ <= '0;
      immQ    <= '0;
      rsQ     <= '0;
      rtQ     <= '0;
      rdQ     <= '0;
    end else begin
      validQ  <= validD;
      ctrlQ   <= ctrlD;
      pc4Q    <= pc4D;
      rsDataQ <= rsDataD;
      rtDataQ <= rtDataD;
      immQ    <= immD;
      rsQ     <= rsD;
      rtQ     <= rtD;
      rdQ     <= rdD;
    end
  end

  // A bubble enters EX on a flush, or on a load of an empty/invalid slot.
  always_comb begin
    bubbleIn = 1'b0;
    unique case (act)
      ActFlush: bubbleIn = 1'b1;
      ActLoad:  bubbleIn = !id_valid || (id_ctrl == '0);
      default:  bubbleIn = 1'b0;
    endcase
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubbleCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (bubbleIn),
    .count (bubble_cnt)
  );

  assign ex_valid   = validQ;
  assign ex_ctrl    = ctrlQ;
  assign ex_pc4     = pc4Q;
  assign ex_rs_data = rsDataQ;
  assign ex_rt_data = rtDataQ;
  assign ex_imm     = immQ;
  assign ex_rs      = rsQ;
  assign ex_rt      = rtQ;
  assign ex_rd      = rdQ;

  // Decoded from registered state only, so no input-to-output path.
  assign ex_memRead = ctrlQ[CTRL_MEMREAD] & validQ;

endmodule

// File: tb/tb_st2_idex_reg.sv
module tb_st2_idex_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned RW = 5;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          id_valid = 1'b0;
  logic [CW-1:0] id_ctrl = '0;
  logic [DW-1:0] id_pc4 = '0;
  logic [DW-1:0] id_rs_data = '0;
  logic [DW-1:0] id_rt_data = '0;
  logic [DW-1:0] id_imm = '0;
  logic [RW-1:0] id_rs = '0;
  logic [RW-1:0] id_rt = '0;
  logic [RW-1:0] id_rd = '0;

  logic          ex_valid;
  logic [CW-1:0] ex_ctrl;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic          ex_memRead;
  logic [NW-1:0] bubble_cnt;

  st2_idex_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .REG_W  (RW),
    .CNT_W  (NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .id_valid   (id_valid),
    .id_ctrl    (id_ctrl),
    .id_pc4     (id_pc4),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .ex_valid   (ex_valid),
    .ex_ctrl    (ex_ctrl),
    .ex_pc4     (ex_pc4),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_imm     (ex_imm),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_memRead (ex_memRead),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what EX should currently hold.
  logic          mValid;
  logic [CW-1:0] mCtrl;
  logic [DW-1:0] mPc4, mRsData, mRtData, mImm;
  logic [RW-1:0] mRs, mRt, mRd;
  int            mCnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mValid = 0; mCtrl = '0; mPc4 = '0; mRsData = '0; mRtData = '0; mImm = '0;
    mRs = '0; mRt = '0; mRd = '0; mCnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   64'(ex_valid),   64'(mValid));
    chk({tag, ".ctrl"},    64'(ex_ctrl),    64'(mCtrl));
    chk({tag, ".pc4"},     64'(ex_pc4),     64'(mPc4));
    chk({tag, ".rsData"},  64'(ex_rs_data), 64'(mRsData));
    chk({tag, ".rtData"},  64'(ex_rt_data), 64'(mRtData));
    chk({tag, ".imm"},     64'(ex_imm),     64'(mImm));
    chk({tag, ".rs"},      64'(ex_rs),      64'(mRs));
    chk({tag, ".rt"},      64'(ex_rt),      64'(mRt));
    chk({tag, ".rd"},      64'(ex_rd),      64'(mRd));
    chk({tag, ".memRead"}, 64'(ex_memRead), 64'(mValid && mCtrl[14]));
    chk({tag, ".cnt"},     64'(bubble_cnt), 64'(mCnt));
  endtask

  // One rising edge: predict from the rules, clock, then compare.
  task automatic step(input string tag);
    bit bubble;
    bubble = flush || (!stall && (!id_valid || id_ctrl == 0));
    if (flush || !stall) begin
      mValid  = flush ? 1'b0 : id_valid;
      mCtrl   = (flush || !id_valid) ? '0 : id_ctrl;
      mPc4    = id_pc4;
      mRsData = id_rs_data;
      mRtData = id_rt_data;
      mImm    = id_imm;
      mRs     = id_rs;
      mRt     = id_rt;
      mRd     = id_rd;
    end
    if (cnt_clr) mCnt = 0;
    else if (bubble && mCnt < 15) mCnt = mCnt + 1;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_id();
    id_valid   = ($urandom_range(0, 3) != 0);
    id_ctrl    = ($urandom_range(0, 5) == 0) ? '0 : CW'($urandom);
    id_pc4     = $urandom;
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm     = $urandom;
    id_rs      = RW'($urandom);
    id_rt      = RW'($urandom);
    id_rd      = RW'($urandom);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    #10;
    rst = 1'b0;

    // Normal load.
    id_valid = 1; id_ctrl = 16'hFC72; id_rs_data = 32'h0000_1234; id_rt = 5'd9;
    id_pc4 = 32'h0000_0104; id_rt_data = 32'hDEAD_BEEF; id_imm = 32'hFFFF_FFF0;
    id_rs = 5'd3; id_rd = 5'd17;
    step("load");
    chk("load.memRead1", 64'(ex_memRead), 64'(1));

    // Stall for three edges while ID changes.
    stall = 1; id_ctrl = 16'h0101; id_rs_data = 32'h0000_5555; id_rt = 5'd2;
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.ctrlHeld", 64'(ex_ctrl), 64'(16'hFC72));
    stall = 0;
    step("release");
    chk("release.ctrl", 64'(ex_ctrl), 64'(16'h0101));

    // Flush wins over stall.
    flush = 1; stall = 1; id_ctrl = 16'hFC72;
    step("flushStall");
    flush = 0; stall = 0;

    // Invalid slot is a bubble.
    id_valid = 0; id_ctrl = 16'hFC72;
    step("invalid");

    // Valid but empty control word also counts as a bubble.
    id_valid = 1; id_ctrl = '0;
    step("zeroCtrl");

    // cnt_clr during stall.
    stall = 1; cnt_clr = 1;
    step("clrStall");
    stall = 0; cnt_clr = 0;

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      rand_id();
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 5) == 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      step("rand");
    end
    stall = 0; flush = 0; cnt_clr = 0;

    // Saturation then clear.
    flush = 1;
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat.cntF", 64'(bubble_cnt), 64'(4'hF));
    cnt_clr = 1;
    step("clrFlush");
    chk("clrFlush.cnt0", 64'(bubble_cnt), 64'(0));
    flush = 0; cnt_clr = 0;

    // Asynchronous reset mid-stall, between edges.
    id_valid = 1; id_ctrl = 16'hFC72; id_rs_data = 32'h0000_1234;
    step("preRst");
    stall = 1; flush = 1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("asyncRst");
    @(negedge clk);
    rst = 1'b0; stall = 0; flush = 0;
    step("postRst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
